// File: rtl/md_sequencer.sv
// Multiply/divide sequencer for the E stage: owns HI/LO, holds Busy for a fixed op latency, then commits.
// Latency MULT_CYCLES/DIV_CYCLES busy cycles after the Start edge; Start while busy is ignored and Stall holds the D stage.
module md_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] D1,
    input  logic [31:0] D2,
    input  logic        MD_use_D,
    output logic        Busy,
    output logic        Stall,
    output logic        Done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] p_hi;
    logic [31:0] p_lo;
    logic        p_ok;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] divisor;
    logic [31:0] quo_mag;
    logic [31:0] rem_mag;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_ok;

    // Signed product is the low 64 bits of the sign-extended unsigned product.
    assign prod_s = {{32{D1[31]}}, D1} * {{32{D2[31]}}, D2};
    assign prod_u = {32'd0, D1} * {32'd0, D2};

    // Signed divide works on magnitudes so 0x80000000 / -1 needs no special case.
    assign neg_a   = (Op == 3'd2) & D1[31];
    assign neg_b   = (Op == 3'd2) & D2[31];
    assign mag_a   = neg_a ? -D1 : D1;
    assign mag_b   = neg_b ? -D2 : D2;
    assign divisor = (D2 == 32'd0) ? 32'd1 : mag_b;
    assign quo_mag = mag_a / divisor;
    assign rem_mag = mag_a % divisor;
    assign quo     = (neg_a ^ neg_b) ? -quo_mag : quo_mag;
    assign rem     = neg_a ? -rem_mag : rem_mag;

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        res_ok = 1'b1;
        case (Op)
            3'd0:       {res_hi, res_lo} = prod_s;
            3'd1:       {res_hi, res_lo} = prod_u;
            3'd2, 3'd3: begin
                res_hi = rem;
                res_lo = quo;
                res_ok = (D2 != 32'd0);
            end
            default:    res_ok = 1'b0;
        endcase
    end

    assign Stall = MD_use_D & (Busy | (Start & ~Op[2]));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
            HI    <= 32'd0;
            LO    <= 32'd0;
            p_hi  <= 32'd0;
            p_lo  <= 32'd0;
            p_ok  <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        if (!Op[2]) begin
                            p_hi  <= res_hi;
                            p_lo  <= res_lo;
                            p_ok  <= res_ok;
                            cnt   <= Op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                            state <= RUN;
                            Busy  <= 1'b1;
                        end else if (Op == 3'd4) begin
                            HI <= D1;
                        end else if (Op == 3'd5) begin
                            LO <= D1;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        // Divide by zero still finishes the sequence but leaves HI/LO alone.
                        if (p_ok) begin
                            HI <= p_hi;
                            LO <= p_lo;
                        end
                        Done  <= 1'b1;
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
